// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default parameters and parity helper
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_DIV   = 868;
  localparam int PARITY_MAX_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Zero-extension to PARITY_MAX_W leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - free-running 0..BAUD_DIV-1 bit timer with synchronous clear
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter popping bytes from the TX FIFO read port
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_SAT  = BCW'(DATA_WIDTH);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic stop_cnt_q, stop_cnt_d;
  logic parity_q, parity_d;
  logic tx_q, tx_d;
  logic baud_clr;
  logic bit_end;

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    baud_clr   = 1'b0;
    fifo_re    = 1'b0;
    tx_done    = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        // Gated by rst_n so the FIFO is never popped while the transmitter is held in reset.
        fifo_re  = !fifo_empty && rst_n;
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        baud_clr   = 1'b1;
        shift_d    = fifo_dout;
        parity_d   = calc_parity(PARITY_MAX_W'(fifo_dout), PARITY_ODD != 0);
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q != BIT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            tx_done = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx changes exactly on state boundaries.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - scoreboard bench for uart_tx_fifo_drain in three parity/stop configurations
module tb_uart_tx_fifo_drain;

  localparam int BAUD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n = 3'b000;
  logic [2:0] fifo_empty, fifo_re, tx, busy, tx_done;
  logic [7:0] fifo_dout [3];
  logic [7:0] mem [3][1024];
  int wr_ptr [3] = '{0, 0, 0};
  int rd_ptr [3] = '{0, 0, 0};
  int re_cnt [3] = '{0, 0, 0};
  int re_empty_viol = 0;
  int re_busy_viol = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] exp_q2 [$];
  int checks = 0;
  int errors = 0;

  // dut0: no parity, 1 stop; dut1: even parity, 2 stops; dut2: odd parity, 1 stop
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
    .fifo_re(fifo_re[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
    .fifo_re(fifo_re[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .fifo_empty(fifo_empty[2]), .fifo_dout(fifo_dout[2]),
    .fifo_re(fifo_re[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
  assign fifo_empty[2] = (wr_ptr[2] == rd_ptr[2]);

  // FIFO read port with registered dout
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_re[i] && (wr_ptr[i] != rd_ptr[i])) begin
        fifo_dout[i] <= mem[i][rd_ptr[i] % 1024];
        rd_ptr[i]    <= rd_ptr[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_re[i] === 1'b1) begin
        re_cnt[i]++;
        if (fifo_empty[i]) re_empty_viol++;
      end
      assert (!(fifo_re[i] === 1'b1 && busy[i] === 1'b1)) else re_busy_viol++;
    end
  end

  task automatic push(input int d, input logic [7:0] b, input bit exp_out);
    mem[d][wr_ptr[d] % 1024] = b;
    wr_ptr[d] = wr_ptr[d] + 1;
    if (exp_out) begin
      case (d)
        0:       exp_q0.push_back(b);
        1:       exp_q1.push_back(b);
        default: exp_q2.push_back(b);
      endcase
    end
  endtask

  // Waits for the next start bit, then checks every clk of the frame and the tx_done position.
  task automatic check_frame(input int d, output int gap);
    logic [7:0] b;
    logic exp_bits [16];
    logic obs;
    int nb, qs, t, done_cnt, done_at;
    bit bad;
    gap = -1;
    case (d)
      0:       qs = exp_q0.size();
      1:       qs = exp_q1.size();
      default: qs = exp_q2.size();
    endcase
    checks++;
    if (qs == 0) begin
      errors++;
      $display("FAIL scoreboard_empty dut%0d: queue size=%0d, required >0", d, qs);
      return;
    end
    case (d)
      0:       b = exp_q0.pop_front();
      1:       b = exp_q1.pop_front();
      default: b = exp_q2.pop_front();
    endcase
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
    nb = 9;
    if (d != 0) begin
      exp_bits[nb] = (d == 2) ? ~^b : ^b;
      nb++;
    end
    for (int s = 0; s < ((d == 1) ? 2 : 1); s++) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    gap = 0;
    t = 0;
    @(negedge clk);
    while (tx[d] === 1'b1 && t < 200) begin
      gap++;
      t++;
      @(negedge clk);
    end
    checks++;
    if (tx[d] !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout dut%0d byte 0x%02h: tx=%b, required 0 within 200 clks", d, b, tx[d]);
      return;
    end
    done_cnt = 0;
    done_at = -1;
    for (int i = 0; i < nb; i++) begin
      bad = 1'b0;
      obs = exp_bits[i];
      for (int k = 0; k < BAUD; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        if (tx[d] !== exp_bits[i]) begin
          bad = 1'b1;
          obs = tx[d];
        end
        if (tx_done[d] === 1'b1) begin
          done_cnt++;
          done_at = i * BAUD + k;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frame_bit dut%0d byte 0x%02h bit %0d: tx=%b, required %b", d, b, i, obs, exp_bits[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != nb * BAUD - 1) begin
      errors++;
      $display("FAIL tx_done dut%0d byte 0x%02h: pulses=%0d at clk %0d, required 1 at clk %0d",
               d, b, done_cnt, done_at, nb * BAUD - 1);
    end
  endtask

  task automatic test_reset();
    int bad_cnt [3];
    rst_n = 3'b000;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({tx[d], busy[d], fifo_re[d], tx_done[d]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: tx/busy/re/done=%b, required 1000", d,
                 {tx[d], busy[d], fifo_re[d], tx_done[d]});
      end
    end
    rst_n = 3'b111;
    bad_cnt = '{0, 0, 0};
    repeat (100) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if ({tx[d], busy[d], fifo_re[d], tx_done[d]} !== 4'b1000) bad_cnt[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (bad_cnt[d] != 0) begin
        errors++;
        $display("FAIL idle_hold dut%0d: %0d non-idle cycles, required 0", d, bad_cnt[d]);
      end
    end
  endtask

  task automatic test_single_byte();
    int c0, gap;
    c0 = re_cnt[0];
    push(0, 8'hA5, 1'b1);
    check_frame(0, gap);
    repeat (3) @(negedge clk);
    checks++;
    if (re_cnt[0] - c0 != 1) begin
      errors++;
      $display("FAIL single_re_count: fifo_re cycles=%0d, required 1", re_cnt[0] - c0);
    end
    checks++;
    if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_after: busy=%b tx=%b, required busy=0 tx=1", busy[0], tx[0]);
    end
  endtask

  task automatic test_back_to_back();
    int c0, gap;
    c0 = re_cnt[0];
    push(0, 8'h00, 1'b1);
    push(0, 8'hFF, 1'b1);
    check_frame(0, gap);
    check_frame(0, gap);
    checks++;
    if (gap != 2) begin
      errors++;
      $display("FAIL b2b_gap: idle clks=%0d, required 2", gap);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (re_cnt[0] - c0 != 2) begin
      errors++;
      $display("FAIL b2b_re_count: fifo_re cycles=%0d, required 2", re_cnt[0] - c0);
    end
  endtask

  task automatic test_parity();
    int gap;
    push(1, 8'h07, 1'b1);
    check_frame(1, gap);
    push(1, 8'hA5, 1'b1);
    check_frame(1, gap);
    push(2, 8'h07, 1'b1);
    check_frame(2, gap);
  endtask

  task automatic test_reset_mid_frame();
    int gap, t;
    push(0, 8'h3C, 1'b0);
    push(0, 8'h55, 1'b1);
    t = 0;
    @(negedge clk);
    while (tx[0] === 1'b1 && t < 200) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_start_timeout: tx=%b, required 0 within 200 clks", tx[0]);
    end
    // Start bit occupies clks 0..3, data bit n occupies clks 4+4n..7+4n.
    repeat (17) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: busy=%b, required 1", busy[0]);
    end
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: tx=%b busy=%b, required tx=1 busy=0", tx[0], busy[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_re[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_re_in_reset: fifo_re=%b, required 0", fifo_re[0]);
    end
    rst_n[0] = 1'b1;
    check_frame(0, gap);
  endtask

  task automatic test_drain_full();
    int c0, gap;
    logic [7:0] b;
    c0 = re_cnt[0];
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      push(0, b, 1'b1);
    end
    for (int i = 0; i < 256; i++) check_frame(0, gap);
    repeat (10) @(negedge clk);
    checks++;
    if (re_cnt[0] - c0 != 256) begin
      errors++;
      $display("FAIL drain_re_count: fifo_re cycles=%0d, required 256", re_cnt[0] - c0);
    end
    checks++;
    if (re_empty_viol != 0) begin
      errors++;
      $display("FAIL re_while_empty: count=%0d, required 0", re_empty_viol);
    end
    checks++;
    if (re_busy_viol != 0) begin
      errors++;
      $display("FAIL re_outside_idle: count=%0d, required 0", re_busy_viol);
    end
    checks++;
    if ({tx[0], busy[0], fifo_re[0]} !== 3'b100) begin
      errors++;
      $display("FAIL drain_final_idle: tx/busy/re=%b, required 100", {tx[0], busy[0], fifo_re[0]});
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    test_drain_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
